// File: rtl/alu_issue_if.sv
// Fetch-to-issue handshake plus the issue stage's operand/instruction bus to the ALU.
// The issue stage uses the master modport; the fetch queue / ALU side uses slave.
interface alu_issue_if;
  logic        fetch_valid;
  logic [15:0] fetch_instr;
  logic        fetch_ready;
  logic [15:0] alu_instr;
  logic [15:0] alu_rs1_data;
  logic [15:0] alu_rs2_data;
  logic        issue_valid;
  logic [15:0] alu_out;
  logic [1:0]  alu_status;
  logic [15:0] alu_ex_instr;

  modport master (
    input  fetch_valid, fetch_instr, alu_out, alu_status, alu_ex_instr,
    output fetch_ready, alu_instr, alu_rs1_data, alu_rs2_data, issue_valid
  );

  modport slave (
    output fetch_valid, fetch_instr, alu_out, alu_status, alu_ex_instr,
    input  fetch_ready, alu_instr, alu_rs1_data, alu_rs2_data, issue_valid
  );
endinterface

// File: rtl/alu_issue.sv
// Issue stage for the 3-stage ALU/multiplier: regfile, RAW forwarding, multiply stall + watchdog.
// Optional macro ALU_ISSUE_PERF_EN adds o_perf_issued / o_perf_stall counters.
module alu_issue #(
  parameter int MUL_LAT = 3,
  parameter int NREGS   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_issue_if.master bus,
  input  logic [3:0]  i_dbg_raddr,
  output logic [15:0] o_dbg_rdata,
  output logic        o_busy,
  output logic        o_illegal,
  output logic        o_mul_err
`ifdef ALU_ISSUE_PERF_EN
  ,
  output logic [31:0] o_perf_issued,
  output logic [31:0] o_perf_stall
`endif
);

  typedef enum logic {ST_RUN, ST_MUL_WAIT} state_t;

  localparam int WD_W = $clog2(MUL_LAT + 2);
  // Counter starts at 0 in the first wait cycle, so this value marks wait cycle MUL_LAT+2.
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MUL_LAT + 1);

  state_t           r_state;
  logic [WD_W-1:0]  r_wd_cnt;
  logic [15:0]      r_regs [NREGS];
  logic [15:0]      r_alu_instr;
  logic [15:0]      r_rs1_data;
  logic [15:0]      r_rs2_data;
  logic             r_issue_valid;
  logic             r_illegal;
  logic             r_mul_err;

  logic [3:0]  w_op;
  logic        w_issue_mul;
  logic        w_sc_we;
  logic        w_mul_done;
  logic        w_wd_fire;
  logic        w_wb_en;
  logic [3:0]  w_wb_addr;
  logic        w_fetch_ready;
  logic        w_accept;
  logic [3:0]  w_rs1_addr;
  logic [3:0]  w_rs2_addr;
  logic [15:0] w_rs1_fwd;
  logic [15:0] w_rs2_fwd;
  logic        w_unused;

  assign w_op        = r_alu_instr[15:12];
  assign w_issue_mul = r_issue_valid && (w_op == 4'h5);
  assign w_sc_we     = r_issue_valid && ((w_op <= 4'h4) || ((w_op >= 4'h6) && (w_op <= 4'hC)));
  assign w_mul_done  = (r_state == ST_MUL_WAIT) && (bus.alu_ex_instr[15:12] == 4'h5);
  assign w_wd_fire   = (r_state == ST_MUL_WAIT) && !w_mul_done && (r_wd_cnt == WD_LAST);

  // Single-cycle writeback and multiply completion never coincide: issue is blocked in MUL_WAIT.
  assign w_wb_en   = w_sc_we || w_mul_done;
  assign w_wb_addr = w_mul_done ? bus.alu_ex_instr[11:8] : r_alu_instr[11:8];

  assign w_fetch_ready = (r_state == ST_RUN) ? !w_issue_mul : w_mul_done;
  assign w_accept      = bus.fetch_valid && w_fetch_ready;

  assign w_rs1_addr = bus.fetch_instr[3:0];
  assign w_rs2_addr = bus.fetch_instr[7:4];
  assign w_rs1_fwd  = (w_wb_en && (w_wb_addr == w_rs1_addr)) ? bus.alu_out : r_regs[w_rs1_addr];
  assign w_rs2_fwd  = (w_wb_en && (w_wb_addr == w_rs2_addr)) ? bus.alu_out : r_regs[w_rs2_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_RUN;
      r_wd_cnt      <= '0;
      r_alu_instr   <= 16'h0000;
      r_rs1_data    <= 16'h0000;
      r_rs2_data    <= 16'h0000;
      r_issue_valid <= 1'b0;
      r_illegal     <= 1'b0;
      r_mul_err     <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= 16'h0000;
      end
    end else begin
      if (w_wb_en) begin
        r_regs[w_wb_addr] <= bus.alu_out;
      end

      if (w_accept) begin
        r_alu_instr   <= bus.fetch_instr;
        r_rs1_data    <= w_rs1_fwd;
        r_rs2_data    <= w_rs2_fwd;
        r_issue_valid <= 1'b1;
        if (bus.fetch_instr[15:12] >= 4'hD) begin
          r_illegal <= 1'b1;
        end
      end else begin
        r_alu_instr   <= 16'h0000;
        r_rs1_data    <= 16'h0000;
        r_rs2_data    <= 16'h0000;
        r_issue_valid <= 1'b0;
      end

      case (r_state)
        ST_RUN: begin
          if (w_issue_mul) begin
            r_state  <= ST_MUL_WAIT;
            r_wd_cnt <= '0;
          end
        end
        ST_MUL_WAIT: begin
          if (w_mul_done) begin
            r_state <= ST_RUN;
          end else if (w_wd_fire) begin
            r_state   <= ST_RUN;
            r_mul_err <= 1'b1;
          end else begin
            r_wd_cnt <= r_wd_cnt + WD_W'(1);
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] r_perf_issued;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_issued <= 32'd0;
      r_perf_stall  <= 32'd0;
    end else begin
      if (w_accept) begin
        r_perf_issued <= r_perf_issued + 32'd1;
      end
      if (bus.fetch_valid && !w_fetch_ready) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
    end
  end

  assign o_perf_issued = r_perf_issued;
  assign o_perf_stall  = r_perf_stall;
`endif

  assign bus.fetch_ready  = w_fetch_ready;
  assign bus.alu_instr    = r_alu_instr;
  assign bus.alu_rs1_data = r_rs1_data;
  assign bus.alu_rs2_data = r_rs2_data;
  assign bus.issue_valid  = r_issue_valid;

  assign o_busy      = (r_state == ST_MUL_WAIT) || w_issue_mul;
  assign o_illegal   = r_illegal;
  assign o_mul_err   = r_mul_err;
  assign o_dbg_rdata = r_regs[i_dbg_raddr];

  // The multiplier's status and the low bits of its departing instruction carry nothing we need.
  assign w_unused = ^{bus.alu_status, bus.alu_ex_instr[7:0]};

endmodule
